// File: rtl/serializer_if.sv
// serializer_if: word handshake between a producer and the serializer.
//   in_data   word to transmit (DATA_WIDTH bits)
//   in_valid  producer has a word on in_data
//   in_ready  serializer holding buffer is empty; a word moves on in_valid && in_ready
// Modports: master = producer side, slave = serializer side.
`timescale 1ns/1ps
interface serializer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serializer.sv
// serializer: parallel-to-serial transmit stage.
// Words arrive over a valid/ready handshake into a 1-entry holding buffer.
// Each word is shifted out MSB first on serial_out. A 1-cycle enable strobe
// marks the first cycle of every bit period, and start accompanies the
// enable of bit 0. A matching deserializer wired port-to-port rebuilds the
// word unchanged.
// Ports:
//   clk        clock, posedge
//   rst_n      synchronous active-low reset
//   bus        serializer_if.slave (in_data, in_valid, in_ready)
//   serial_out current serial bit, held for the whole bit period and while idle
//   enable     strobe on the first cycle of each bit period
//   start      high with the enable of bit 0 only
//   busy       shifting, in inter-frame gap, or holding a buffered word
//   frame_cnt  completed frames (16-bit, wraps)
// Optional feature: define SER_FRAME_CNT_EN to build the frame counter;
// without it frame_cnt is constant zero.
`timescale 1ns/1ps
module serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_PERIOD = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  serializer_if.slave bus,
  output logic        serial_out,
  output logic        enable,
  output logic        start,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int TMR_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] buf_r;
  logic                  buf_full_r, buf_full_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic [TMR_W-1:0]      tmr_r, tmr_s;
  logic [GAP_W-1:0]      gap_cnt_r, gap_cnt_s;
  logic                  take_s;
  logic                  accept_s;
  logic                  enable_s, start_s, serial_out_s, busy_s;
  logic                  serial_out_r, enable_r, start_r, busy_r;

  assign accept_s     = bus.in_valid && !buf_full_r;
  assign bus.in_ready = ~buf_full_r;
  assign serial_out   = serial_out_r;
  assign enable       = enable_r;
  assign start        = start_r;
  assign busy         = busy_r;

  // Next-state logic: frame sequencing, bit timer, gap timer and buffer hand-off.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bit_cnt_s = bit_cnt_r;
    tmr_s     = tmr_r;
    gap_cnt_s = gap_cnt_r;
    take_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buf_full_r) begin
          take_s    = 1'b1;
          shreg_s   = buf_r;
          bit_cnt_s = '0;
          tmr_s     = '0;
          state_s   = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tmr_r == TMR_LAST) begin
          shreg_s   = {shreg_r[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r + 1'b1;
          tmr_s     = '0;
          if (bit_cnt_r == BIT_LAST) begin
            // Last bit period ends: gap first, otherwise chain straight into
            // the buffered word so back-to-back frames keep enable continuous.
            if (GAP_CYCLES > 0) begin
              gap_cnt_s = '0;
              state_s   = ST_GAP;
            end else if (buf_full_r) begin
              take_s    = 1'b1;
              shreg_s   = buf_r;
              bit_cnt_s = '0;
              state_s   = ST_SHIFT;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          tmr_s = tmr_r + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (buf_full_r) begin
            take_s    = 1'b1;
            shreg_s   = buf_r;
            bit_cnt_s = '0;
            tmr_s     = '0;
            state_s   = ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          gap_cnt_s = gap_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    enable_s     = (state_r == ST_SHIFT) && (tmr_r == '0);
    start_s      = enable_s && (bit_cnt_r == '0);
    serial_out_s = serial_out_r;
    if (enable_s) begin
      serial_out_s = shreg_r[DATA_WIDTH-1];
    end else begin
      serial_out_s = serial_out_r;
    end
    // Accept and take are mutually exclusive because in_ready is low while full.
    if (accept_s) begin
      buf_full_s = 1'b1;
    end else if (take_s) begin
      buf_full_s = 1'b0;
    end else begin
      buf_full_s = buf_full_r;
    end
    busy_s = (state_s != ST_IDLE) || buf_full_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      buf_r        <= '0;
      buf_full_r   <= 1'b0;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      tmr_r        <= '0;
      gap_cnt_r    <= '0;
      serial_out_r <= 1'b0;
      enable_r     <= 1'b0;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      buf_full_r   <= buf_full_s;
      shreg_r      <= shreg_s;
      bit_cnt_r    <= bit_cnt_s;
      tmr_r        <= tmr_s;
      gap_cnt_r    <= gap_cnt_s;
      serial_out_r <= serial_out_s;
      enable_r     <= enable_s;
      start_r      <= start_s;
      busy_r       <= busy_s;
      if (accept_s) begin
        buf_r <= bus.in_data;
      end else begin
        buf_r <= buf_r;
      end
    end
  end

`ifdef SER_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;
  logic        frame_end_s;

  assign frame_end_s = (state_r == ST_SHIFT) && (tmr_r == TMR_LAST) && (bit_cnt_r == BIT_LAST);
  assign frame_cnt   = frame_cnt_r;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'h0000;
    end else if (frame_end_s) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
